product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter WL, default 32, the operand word length of the upstream multiplier; product width is 2*WL.
REQ-002 The block SHALL have parameter ACC_LEN, default 4, the number of products summed per result; legal range 2..256.
REQ-003 The block SHALL define localparam CW = $clog2(ACC_LEN) and SW = 2*WL + CW (sum width).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0); release is synchronous to clk.
REQ-006 in_valid  input  1  product strobe; driven by the upstream multiplier done output.
REQ-007 in_product  input  2*WL  unsigned product; sampled only when in_valid=1.
REQ-008 clear  input  1  synchronous flush of the partial accumulation and sticky flag.
REQ-009 sum_valid  output  1  result available.
REQ-010 sum_ready  input  1  downstream accepts the result.
REQ-011 sum  output  SW  unsigned sum of ACC_LEN consecutive accepted products.
REQ-012 beat_cnt  output  CW  number of products accumulated into the current partial sum.
REQ-013 overrun  output  1  sticky: a completed sum was lost because the output register was occupied.

Function
REQ-014 The block SHALL have no in_valid back-pressure; every in_valid=1 cycle (clear=0) SHALL be accumulated.
REQ-015 The accumulator SHALL be SW bits wide and unsigned; no wrap is possible for ACC_LEN products of 2*WL bits.
REQ-016 On an in_valid cycle with beat_cnt < ACC_LEN-1: acc <= acc + in_product, beat_cnt <= beat_cnt + 1.
REQ-017 On an in_valid cycle with beat_cnt = ACC_LEN-1 (completing beat): the completed value acc + in_product SHALL be offered to the output register, and acc <= 0 and beat_cnt <= 0 on the same edge.
REQ-018 The output register SHALL load the completed value when sum_valid=0, or when sum_valid=1 and sum_ready=1 in that cycle; sum_valid SHALL then be 1 on the next cycle (latency: 1 clock after the completing beat).
REQ-019 If a completing beat occurs while sum_valid=1 and sum_ready=0, the completed value SHALL be discarded, sum and sum_valid SHALL hold, and overrun SHALL set to 1 on the next edge.
REQ-020 A handshake occurs when sum_valid=1 and sum_ready=1; without a simultaneous load, sum_valid SHALL drop to 0 on the next edge.
REQ-021 sum and sum_valid SHALL remain stable while sum_valid=1 and sum_ready=0.
REQ-022 clear=1 SHALL set acc to 0, beat_cnt to 0 and overrun to 0 on the next edge, and SHALL take priority over in_valid in the same cycle (that product is dropped, not counted as overrun).
REQ-023 clear SHALL NOT affect sum, sum_valid or a pending handshake.
REQ-024 sum_ready while sum_valid=0 SHALL have no effect.
REQ-025 The output register SHALL be modelled as a two-state FSM: EMPTY (sum_valid=0) and FULL (sum_valid=1); EMPTY->FULL on load, FULL->EMPTY on handshake without load, FULL->FULL on load with handshake or on stall.

Reset
REQ-026 While reset=0: acc=0, beat_cnt=0, sum=0, sum_valid=0, overrun=0, asynchronously.
REQ-027 Reset asserted mid-accumulation or with sum_valid=1 SHALL discard all partial and pending data; first in_valid after release SHALL be beat 0.

Verification
REQ-028 WL=8, ACC_LEN=4, sum_ready=1: in_valid with products 10,20,30,40 back-to-back -> sum_valid=1 with sum=100 one clock after 4th beat, for one cycle.
REQ-029 Max values: four products of 65025 -> sum=260100 (18 bits), no truncation.
REQ-030 sum_ready=0 holding sum=100; four further products complete -> sum stays 100, overrun=1; then clear -> overrun=0, sum_valid still 1.
REQ-031 sum_valid=1 with sum_ready=1 in the same cycle as the next completing beat (products 1,1,1,1) -> sum=4 next cycle, sum_valid stays 1, overrun=0.
REQ-032 Products 5,5 then clear with in_valid=1 (product 5) then 1,2,3,4 -> sum=10; beat_cnt=0 after clear.
REQ-033 reset=0 pulse after 2 beats with sum_valid=1 -> all outputs 0 immediately; products 1,1,1,1 after release -> sum=4.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums ACC_LEN consecutive unsigned products from an upstream multiplier into one wide result.
// Latency: result visible on sum/sum_valid one clock after the completing product beat.
// Backpressure: none on the product input; a result that completes while the output is stalled is dropped and flagged on overrun.
module product_accumulator #(
    parameter int WL      = 32,
    parameter int ACC_LEN = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    input  logic [2*WL-1:0]                           in_product,
    input  logic                                      clear,
    output logic                                      sum_valid,
    input  logic                                      sum_ready,
    output logic [2*WL+$clog2(ACC_LEN)-1:0]           sum,
    output logic [$clog2(ACC_LEN)-1:0]                beat_cnt,
    output logic                                      overrun
);

    // Counter width and sum width: CW extra bits absorb the carries of ACC_LEN full-scale products.
    localparam int CW = $clog2(ACC_LEN);
    localparam int SW = 2*WL + CW;

    // Beat index of the product that completes a group.
    localparam logic [CW-1:0] LAST_BEAT = CW'(ACC_LEN - 1);

    // Output register occupancy.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_beat;
    logic [SW-1:0] r_sum;
    out_state_t    r_state;
    logic          r_overrun;

    // ------------------------------------------------------------------
    // Per-cycle decode
    // ------------------------------------------------------------------
    logic          w_accept;
    logic          w_complete;
    logic [SW-1:0] w_total;
    logic          w_full;
    logic          w_handshake;
    logic          w_load;
    logic          w_lost;

    // A product is taken only when clear is low; clear drops it outright.
    assign w_accept    = in_valid && !clear;
    assign w_complete  = w_accept && (r_beat == LAST_BEAT);

    // Zero-extended running sum including this cycle's product.
    assign w_total     = r_acc + {{CW{1'b0}}, in_product};

    assign w_full      = (r_state == S_FULL);
    assign w_handshake = w_full && sum_ready;

    // The output register can accept a new result if empty or being drained this cycle.
    assign w_load      = w_complete && (!w_full || sum_ready);

    // A completed result with nowhere to go is discarded.
    assign w_lost      = w_complete && w_full && !sum_ready;

    // ------------------------------------------------------------------
    // Partial accumulation and beat counter
    // ------------------------------------------------------------------

    // Accumulate accepted products; restart after the completing beat or on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (clear) begin
            r_acc  <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_acc  <= '0;
                r_beat <= '0;
            end else begin
                r_acc  <= w_total;
                r_beat <= r_beat + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register FSM
    // ------------------------------------------------------------------

    // EMPTY/FULL tracking of the result register; sum is only written on a load so it holds through stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_sum   <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_load) begin
                        r_sum   <= w_total;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_load) begin
                        // Drained and refilled on the same edge.
                        r_sum   <= w_total;
                        r_state <= S_FULL;
                    end else if (w_handshake) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky overrun flag
    // ------------------------------------------------------------------

    // Set when a result is lost to a stalled output; only clear or reset lowers it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_lost) begin
            r_overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sum_valid = w_full;
    assign sum       = r_sum;
    assign beat_cnt  = r_beat;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: queue-based reference model checked every cycle, plus hand-computed scenarios.
// Inputs change 1 time unit after the falling edge; outputs are compared on the falling edge.
// Finishes after a fixed number of directed and random cycles.
module tb_product_accumulator;

    localparam int WL      = 8;
    localparam int ACC_LEN = 4;
    localparam int CW      = $clog2(ACC_LEN);
    localparam int SW      = 2*WL + CW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [2*WL-1:0]   in_product = '0;
    logic              clear = 1'b0;
    logic              sum_ready = 1'b0;
    logic              sum_valid;
    logic [SW-1:0]     sum;
    logic [CW-1:0]     beat_cnt;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    product_accumulator #(.WL(WL), .ACC_LEN(ACC_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_product (in_product),
        .clear      (clear),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum        (sum),
        .beat_cnt   (beat_cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: products collected in a queue, summed when ACC_LEN are present.
    longint unsigned q[$];
    logic            m_valid = 1'b0;
    longint unsigned m_sum   = 0;
    logic            m_ovr   = 1'b0;

    always @(posedge clk or negedge reset) begin
        longint unsigned total;
        logic            done;
        logic            drained;
        if (!reset) begin
            q.delete();
            m_valid = 1'b0;
            m_sum   = 0;
            m_ovr   = 1'b0;
        end else begin
            drained = m_valid && sum_ready;
            done    = 1'b0;
            total   = 0;
            if (clear) begin
                q.delete();
                m_ovr = 1'b0;
            end else if (in_valid) begin
                q.push_back(longint'(in_product));
                if (q.size() == ACC_LEN) begin
                    foreach (q[k]) total += q[k];
                    q.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || sum_ready) begin
                    m_sum   = total;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (drained) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    bit cmp_en = 1'b1;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_sum_valid", longint'(sum_valid), longint'(m_valid));
            check("model_sum",       longint'(sum),       m_sum);
            check("model_beat_cnt",  longint'(beat_cnt),  longint'(q.size()));
            check("model_overrun",   longint'(overrun),   longint'(m_ovr));
        end
    end

    // Apply one cycle of inputs, return just after the following falling edge.
    task automatic drive(input logic v, input logic [2*WL-1:0] p, input logic c, input logic r);
        in_valid   = v;
        in_product = p;
        clear      = c;
        sum_ready  = r;
        @(negedge clk);
        #1;
    endtask

    task automatic group4(input logic [2*WL-1:0] a, input logic [2*WL-1:0] b,
                          input logic [2*WL-1:0] c, input logic [2*WL-1:0] d, input logic r);
        drive(1'b1, a, 1'b0, r);
        drive(1'b1, b, 1'b0, r);
        drive(1'b1, c, 1'b0, r);
        drive(1'b1, d, 1'b0, r);
    endtask

    initial begin
        // Reset state.
        #2;
        check("reset_sum_valid", longint'(sum_valid), 0);
        check("reset_sum",       longint'(sum),       0);
        check("reset_beat_cnt",  longint'(beat_cnt),  0);
        check("reset_overrun",   longint'(overrun),   0);
        @(negedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b1);

        // Basic group with ready high: result for exactly one cycle.
        group4(10, 20, 30, 40, 1'b1);
        check("basic_valid", longint'(sum_valid), 1);
        check("basic_sum",   longint'(sum),       100);
        drive(1'b0, 0, 1'b0, 1'b1);
        check("basic_valid_drop", longint'(sum_valid), 0);

        // Full-scale products, no truncation.
        group4(16'd65025, 16'd65025, 16'd65025, 16'd65025, 1'b1);
        check("max_sum", longint'(sum), 260100);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Stalled output: second result lost, overrun set, clear lowers it only.
        group4(10, 20, 30, 40, 1'b0);
        check("stall_valid", longint'(sum_valid), 1);
        group4(7, 7, 7, 7, 1'b0);
        check("stall_sum_hold", longint'(sum),     100);
        check("stall_overrun",  longint'(overrun), 1);
        drive(1'b0, 0, 1'b1, 1'b0);
        check("clear_overrun",     longint'(overrun),   0);
        check("clear_valid_kept",  longint'(sum_valid), 1);
        check("clear_sum_kept",    longint'(sum),       100);
        drive(1'b0, 0, 1'b0, 1'b1);
        check("drain_after_clear", longint'(sum_valid), 0);

        // Handshake coinciding with the next completing beat.
        group4(2, 2, 2, 2, 1'b1);
        check("b2b_first_sum", longint'(sum), 8);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b1);
        check("b2b_sum",     longint'(sum),       4);
        check("b2b_valid",   longint'(sum_valid), 1);
        check("b2b_overrun", longint'(overrun),   0);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Clear wins over a simultaneous product.
        drive(1'b1, 5, 1'b0, 1'b1);
        drive(1'b1, 5, 1'b0, 1'b1);
        check("pre_clear_beat", longint'(beat_cnt), 2);
        drive(1'b1, 5, 1'b1, 1'b1);
        check("clear_beat", longint'(beat_cnt), 0);
        group4(1, 2, 3, 4, 1'b1);
        check("clear_sum", longint'(sum), 10);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-accumulation with a pending result.
        group4(3, 3, 3, 3, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 1, 1'b0, 1'b0);
        check("pre_rst_valid", longint'(sum_valid), 1);
        check("pre_rst_beat",  longint'(beat_cnt),  2);
        reset = 1'b0;
        #1;
        check("rst_sum_valid", longint'(sum_valid), 0);
        check("rst_sum",       longint'(sum),       0);
        check("rst_beat_cnt",  longint'(beat_cnt),  0);
        check("rst_overrun",   longint'(overrun),   0);
        @(negedge clk); #1;
        reset = 1'b1;
        group4(1, 1, 1, 1, 1'b1);
        check("post_rst_sum",   longint'(sum),       4);
        check("post_rst_valid", longint'(sum_valid), 1);
        drive(1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  16'($urandom_range(0, 65025)),
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 1)));
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
